// File: rtl/pong_pkg.sv
// pong_pkg: shared state/winner codes, widths and helpers for the Pong match sequencer
package pong_pkg;
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_GOAL  = 3'd3,
      ST_OVER  = 3'd4
   } state_t;
   localparam int SCORE_W = 4;
   localparam logic [1:0] WIN_NONE = 2'd0;
   localparam logic [1:0] WIN_A    = 2'd1;
   localparam logic [1:0] WIN_B    = 2'd2;
   localparam logic [11:0] WRAP_Y  = 12'd2048;
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s, input logic [SCORE_W-1:0] lim);
      return (s >= lim) ? s : s + 1'b1;
   endfunction
endpackage

// File: rtl/pong_game_ctrl_frame_timer.sv
// frame_timer: loadable 8-bit down-counter of animation strobes, done on a strobe at zero
module frame_timer (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_load,
   input  logic [7:0] i_load_val,
   input  logic       i_stb,
   output logic       o_done
);
   logic [7:0] r_cnt;
   // load wins over counting; the counter parks at zero
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_cnt <= 8'd0;
      else if (i_load) r_cnt <= i_load_val;
      else if (i_stb && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
   end
   assign o_done = i_stb && (r_cnt == 8'd0);
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match sequencer (serve hold, goal detection, scoring, winner)
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int GOAL_TOP     = 10,
   parameter int GOAL_BOTTOM  = 470,
   parameter int SERVE_FRAMES = 60,
   parameter int GOAL_FRAMES  = 90,
   parameter int WIN_SCORE    = 7
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_ani_stb,
   input  logic               i_start,
   input  logic [11:0]        i_ball_y,
   output logic               o_animate,
   output logic               o_ball_rst,
   output logic [SCORE_W-1:0] o_score_a,
   output logic [SCORE_W-1:0] o_score_b,
   output logic [2:0]         o_state,
   output logic [1:0]         o_winner
);
   localparam logic [11:0]        LP_TOP   = 12'(GOAL_TOP);
   localparam logic [11:0]        LP_BOT   = 12'(GOAL_BOTTOM);
   localparam logic [7:0]         LP_SERVE = 8'(SERVE_FRAMES - 1);
   localparam logic [7:0]         LP_GOAL  = 8'(GOAL_FRAMES - 1);
   localparam logic [SCORE_W-1:0] LP_WIN   = SCORE_W'(WIN_SCORE);

   state_t             r_state;
   logic               r_start_q;
   logic [SCORE_W-1:0] r_score_a, r_score_b;
   logic [1:0]         r_winner;
   logic               w_start_edge, w_goal_b, w_goal_a, w_goal, w_win_a, w_win_b, w_win;
   logic               w_load, w_done;
   logic [7:0]         w_load_val;

   assign w_start_edge = i_start & ~r_start_q;
   assign w_goal_b     = (i_ball_y >= LP_BOT) && (i_ball_y < WRAP_Y);
   assign w_goal_a     = !w_goal_b && ((i_ball_y <= LP_TOP) || (i_ball_y >= WRAP_Y));
   assign w_goal       = i_ani_stb && (w_goal_a || w_goal_b);
   assign w_win_a      = r_score_a == LP_WIN;
   assign w_win_b      = r_score_b == LP_WIN;
   assign w_win        = w_win_a || w_win_b;
   assign w_load       = (((r_state == ST_IDLE) || (r_state == ST_OVER)) && w_start_edge)
                       || ((r_state == ST_PLAY) && w_goal)
                       || ((r_state == ST_GOAL) && w_done && !w_win);
   assign w_load_val   = (r_state == ST_PLAY) ? LP_GOAL : LP_SERVE;

   frame_timer u_timer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_stb      (i_ani_stb),
      .o_done     (w_done)
   );

   // match FSM with score and winner registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_start_q <= 1'b0;
         r_score_a <= '0;
         r_score_b <= '0;
         r_winner  <= WIN_NONE;
      end else begin
         r_start_q <= i_start;
         case (r_state)
            ST_IDLE:  if (w_start_edge) r_state <= ST_SERVE;
            ST_SERVE: if (w_done) r_state <= ST_PLAY;
            ST_PLAY: if (w_goal) begin
               r_state <= ST_GOAL;
               if (w_goal_b) r_score_b <= sat_inc(r_score_b, LP_WIN);
               else r_score_a <= sat_inc(r_score_a, LP_WIN);
            end
            ST_GOAL: if (w_done) begin
               r_state  <= w_win ? ST_OVER : ST_SERVE;
               r_winner <= w_win_a ? WIN_A : (w_win_b ? WIN_B : WIN_NONE);
            end
            ST_OVER: if (w_start_edge) begin
               r_state   <= ST_SERVE;
               r_score_a <= '0;
               r_score_b <= '0;
               r_winner  <= WIN_NONE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_animate  = r_state == ST_PLAY;
   assign o_ball_rst = (r_state == ST_IDLE) || (r_state == ST_SERVE) || (r_state == ST_OVER);
   assign o_score_a  = r_score_a;
   assign o_score_b  = r_score_b;
   assign o_state    = r_state;
   assign o_winner   = r_winner;
endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Match sequencer for the Pong datapath. It sits between the frame-strobe generator and the ball/paddle animators, and decides when the ball is held at centre, served or frozen after a goal. It detects goals from the ball's vertical position, keeps both players' scores and declares a winner. The ball animator is driven only through this block's `o_animate` / `o_ball_rst` outputs.

## Interface
Parameters:
- `GOAL_TOP`, 10: ball centre y at or below this value is a goal for player A (bottom paddle).
- `GOAL_BOTTOM`, 470: ball centre y at or above this value is a goal for player B (top paddle).
- `SERVE_FRAMES`, 60: frames the ball is held at centre before play starts.
- `GOAL_FRAMES`, 90: frames the ball is frozen after a goal.
- `WIN_SCORE`, 7: score that ends the match; must be ≤ 15.

Ports:
- `i_clk`  in  1  base clock; the only clock.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_ani_stb`  in  1  one-cycle animation strobe, one per frame.
- `i_start`  in  1  start button level, already synchronised and debounced.
- `i_ball_y`  in  12  ball centre y, 0-4095.
- `o_animate`  out  1  enables ball motion.
- `o_ball_rst`  out  1  holds the ball at its initial position.
- `o_score_a`  out  4  player A score.
- `o_score_b`  out  4  player B score.
- `o_state`  out  3  current FSM state code.
- `o_winner`  out  2  0 = none, 1 = A, 2 = B.

## Operation
States and codes: IDLE=0, SERVE=1, PLAY=2, GOAL=3, OVER=4.

Start edge detection:
- `i_start` is registered internally.
- A start edge is `i_start & ~start_q`, evaluated on every clock, not gated by the strobe.

Transitions:
- IDLE → SERVE on a start edge. The frame counter loads `SERVE_FRAMES-1`.
- SERVE: the counter decrements on each `i_ani_stb`. On a strobe with counter = 0 → PLAY.
- PLAY: goal checks happen only on `i_ani_stb`.
  - Bottom check: `i_ball_y >= GOAL_BOTTOM` and `i_ball_y < 2048` → B scores.
  - Top check: `i_ball_y <= GOAL_TOP` or `i_ball_y >= 2048` (treated as underflow wrap) → A scores.
  - The bottom check has priority.
  - On either goal: increment the scorer's score, load `GOAL_FRAMES-1` → GOAL.
- GOAL: the counter decrements on each strobe. On a strobe with counter = 0:
  - if either score equals `WIN_SCORE` → OVER, with `o_winner` set to the scorer;
  - otherwise → SERVE, counter loads `SERVE_FRAMES-1`.
- OVER: on a start edge, clear scores and winner → SERVE.
- A start edge in SERVE, PLAY or GOAL is ignored.

Outputs:
- `o_animate` = 1 only in PLAY.
- `o_ball_rst` = 1 in IDLE, SERVE and OVER; 0 in PLAY and GOAL. GOAL freezes the ball where it crossed.
- Scores saturate at `WIN_SCORE` and never wrap.

## Timing
- Reset (`i_rst_n`=0 at a clock edge):
  - state IDLE, counter 0, start_q 0;
  - `o_score_a` = `o_score_b` = 0, `o_winner` = 0;
  - `o_animate` = 0, `o_ball_rst` = 1.
- Reset has priority over every event, including a strobe in the same cycle. Reset mid-PLAY takes effect at the next edge.
- State, scores, counter and winner are registers. `o_animate` / `o_ball_rst` decode from the state register, so they change in the cycle after the transition edge.
- Goal-to-score latency: 1 clock after the strobe edge.
- Total frozen interval after a goal: exactly `GOAL_FRAMES` strobes, then `SERVE_FRAMES` strobes in SERVE.
- Simultaneous start edge and strobe in IDLE: go to SERVE; that strobe is not counted.
- The counter is 8 bits; `SERVE_FRAMES` and `GOAL_FRAMES` must be in 1..256.

## Structure
- Shared package `pong_pkg` holds:
  - state codes (`ST_IDLE`…`ST_OVER`);
  - winner codes;
  - `SCORE_W` = 4;
  - the 2048 wrap threshold.
- One sub-module, `frame_timer`: a loadable 8-bit down-counter with inputs `load`, `load_val` and `stb`, and output `done` (counter = 0 & stb).
- The top-level FSM instantiates a single `frame_timer`, shared by SERVE and GOAL.

## Test plan
- Reset with `i_start`=1 held → IDLE, `o_ball_rst`=1, scores 0. Release then re-press start → SERVE; PLAY after exactly 60 strobes.
- In PLAY, drive `i_ball_y`=470 on a strobe → `o_score_b`=1 next clock, GOAL. After 90 strobes → SERVE, `o_ball_rst`=1.
- In PLAY, drive `i_ball_y`=4095 (wrap) on a strobe → `o_score_a` increments. `i_ball_y`=470 without a strobe → no change.
- Score A six times, then a seventh goal → after GOAL, OVER with `o_winner`=1 and `o_animate`=0. A start edge clears scores → SERVE.
- Deassert `i_rst_n` in the same cycle as a goal strobe mid-PLAY → IDLE with scores 0; the goal is not counted.
- Start pressed during PLAY and GOAL → no state change.
